// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store initiator driving the data-cache port.
// Aligned accesses pass straight through in the same cycle; misaligned loads
// become two word reads merged in LD_HI, misaligned stores become a run of byte
// writes in ST_BYTE, with Lsu_Stall freezing the pipeline meanwhile.
// Build option: define MISALIGN_TRAP_EN to trap misaligned requests
// (Lsu_MisalignErr pulse, no cache access) instead of splitting them.
module mem_lsu #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EXMem_LdEN,
    input  logic                  EXMem_StEN,
    input  logic [1:0]            EXMem_Width,
    input  logic                  EXMem_Sign,
    input  logic [ADDR_WIDTH-1:0] EXMem_Addr,
    input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
    output logic                  Mem_DcacheEN,
    output logic                  Mem_DcacheRd,
    output logic [1:0]            Mem_DcacheWidth,
    output logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    output logic                  Mem_DcacheSign,
    output logic [DATA_WIDTH-1:0] Mem_DcacheWrData,
    input  logic [DATA_WIDTH-1:0] Dcache_DataRd,
    output logic [DATA_WIDTH-1:0] Lsu_LdData,
    output logic                  Lsu_LdValid,
    output logic                  Lsu_Stall,
    output logic                  Lsu_MisalignErr
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_BAD  = 2'b11;

    typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_t;

    state_t                  state;
    logic [1:0]              byte_cnt;
    logic [DATA_WIDTH-1:0]   lo_reg;

    logic                    req_ld;
    logic                    req_st;
    logic                    req_ok;
    logic                    misalign;
    logic                    split_ld;
    logic                    split_st;
    logic                    last_byte;
    logic [1:0]              cnt_sel;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [ADDR_WIDTH-1:0]   byte_addr;
    logic [7:0]              store_byte;
    logic [DATA_WIDTH-1:0]   merge_sh;
    logic [DATA_WIDTH-1:0]   merge_data;

    // Request decode: load wins over store, width 11 is never serviced
    assign req_ld    = EXMem_LdEN;
    assign req_st    = EXMem_StEN & ~EXMem_LdEN;
    assign req_ok    = (req_ld | req_st) & (EXMem_Width != W_BAD);
    assign misalign  = ((EXMem_Width == W_HALF) && (EXMem_Addr[1:0] == 2'b11)) ||
                       ((EXMem_Width == W_WORD) && (EXMem_Addr[1:0] != 2'b00));
    assign split_ld  = req_ld & req_ok & misalign & ~TRAP;
    assign split_st  = req_st & req_ok & misalign & ~TRAP;
    assign last_byte = (byte_cnt == ((EXMem_Width == W_HALF) ? 2'd1 : 2'd3));

    // Split addressing and data selection
    assign cnt_sel    = (state == ST_BYTE) ? byte_cnt : 2'd0;
    assign word_addr  = {EXMem_Addr[ADDR_WIDTH-1:2], 2'b00};
    assign byte_addr  = EXMem_Addr + ADDR_WIDTH'(cnt_sel);
    assign store_byte = EXMem_Rs2Data[{cnt_sel, 3'b000} +: 8];

    // Merge high word with captured low word and extend to the requested width
    assign merge_sh   = DATA_WIDTH'({Dcache_DataRd, lo_reg} >> {EXMem_Addr[1:0], 3'b000});
    assign merge_data = (EXMem_Width == W_HALF) ?
                        {{(DATA_WIDTH-16){EXMem_Sign & merge_sh[15]}}, merge_sh[15:0]} :
                        merge_sh;

    // State, byte counter and low-word capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            lo_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (split_ld) begin
                        lo_reg <= Dcache_DataRd;
                        state  <= LD_HI;
                    end else if (split_st) begin
                        byte_cnt <= 2'd1;
                        state    <= ST_BYTE;
                    end
                end
                LD_HI: begin
                    state <= IDLE;
                end
                ST_BYTE: begin
                    if (last_byte) begin
                        byte_cnt <= 2'd0;
                        state    <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cache port, load return and stall; everything forced low during reset
    always_comb begin
        Mem_DcacheEN     = 1'b0;
        Mem_DcacheRd     = 1'b0;
        Mem_DcacheWidth  = W_BYTE;
        Mem_DcacheAddr   = '0;
        Mem_DcacheSign   = 1'b0;
        Mem_DcacheWrData = '0;
        Lsu_LdData       = '0;
        Lsu_LdValid      = 1'b0;
        Lsu_Stall        = 1'b0;
        Lsu_MisalignErr  = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        if (!misalign) begin
                            Mem_DcacheEN     = 1'b1;
                            Mem_DcacheRd     = req_ld;
                            Mem_DcacheWidth  = EXMem_Width;
                            Mem_DcacheAddr   = EXMem_Addr;
                            Mem_DcacheSign   = EXMem_Sign;
                            Mem_DcacheWrData = EXMem_Rs2Data;
                            if (req_ld) begin
                                Lsu_LdData  = Dcache_DataRd;
                                Lsu_LdValid = 1'b1;
                            end
                        end else if (TRAP) begin
                            Lsu_MisalignErr = 1'b1;
                        end else if (req_ld) begin
                            Mem_DcacheEN    = 1'b1;
                            Mem_DcacheRd    = 1'b1;
                            Mem_DcacheWidth = W_WORD;
                            Mem_DcacheAddr  = word_addr;
                            Lsu_Stall       = 1'b1;
                        end else begin
                            Mem_DcacheEN     = 1'b1;
                            Mem_DcacheWidth  = W_BYTE;
                            Mem_DcacheAddr   = byte_addr;
                            Mem_DcacheWrData = DATA_WIDTH'(store_byte);
                            Lsu_Stall        = 1'b1;
                        end
                    end
                end
                LD_HI: begin
                    Mem_DcacheEN    = 1'b1;
                    Mem_DcacheRd    = 1'b1;
                    Mem_DcacheWidth = W_WORD;
                    Mem_DcacheAddr  = word_addr + ADDR_WIDTH'(4);
                    Lsu_LdData      = merge_data;
                    Lsu_LdValid     = 1'b1;
                end
                ST_BYTE: begin
                    Mem_DcacheEN     = 1'b1;
                    Mem_DcacheWidth  = W_BYTE;
                    Mem_DcacheAddr   = byte_addr;
                    Mem_DcacheWrData = DATA_WIDTH'(store_byte);
                    Lsu_Stall        = ~last_byte;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator that drives the data-memory port from the MEM stage.
- Converts pipeline load/store requests into cache transactions: enable, read/write, width, address, sign and store data.
- Aligned accesses pass through in one cycle.
- Misaligned accesses are split into sequential word reads (loads) or byte writes (stores); the pipeline stalls meanwhile.
- Merged load data is returned to the writeback path.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- EXMem_LdEN  input  1  load request, held stable while Lsu_Stall=1
- EXMem_StEN  input  1  store request, held stable while Lsu_Stall=1
- EXMem_Width  input  2  00 byte, 01 halfword, 10 word, 11 invalid
- EXMem_Sign  input  1  sign-extend load result
- EXMem_Addr  input  ADDR_WIDTH  byte address
- EXMem_Rs2Data  input  DATA_WIDTH  store data, LSB-aligned
- Mem_DcacheEN  output  1  cache access enable
- Mem_DcacheRd  output  1  1 read, 0 write
- Mem_DcacheWidth  output  2  cache access width
- Mem_DcacheAddr  output  ADDR_WIDTH  cache byte address
- Mem_DcacheSign  output  1  cache sign-extend
- Mem_DcacheWrData  output  DATA_WIDTH  store data to cache
- Dcache_DataRd  input  DATA_WIDTH  cache read data (combinational, same cycle)
- Lsu_LdData  output  DATA_WIDTH  final load result
- Lsu_LdValid  output  1  Lsu_LdData valid this cycle
- Lsu_Stall  output  1  freeze IF..MEM stages
- Lsu_MisalignErr  output  1  misalignment trap pulse (optional feature only)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, byte counter=0, low-word capture register=0.
  - All outputs 0 while in reset.
  - Reset mid-split aborts; bytes already stored stay written (no rollback).
- Misaligned condition:
  - Width=01 and Addr[1:0]=11.
  - Width=10 and Addr[1:0]!=00.
- Request priority: LdEN and StEN both set is illegal; load wins.
- Width=11: no cache enable, no stall, LdValid=0.
- States: IDLE, LD_HI, ST_BYTE.
- IDLE, aligned request:
  - Drive cache combinationally: EN=1, Rd=LdEN, Width/Sign/Addr/WrData from inputs.
  - Load: LdData=Dcache_DataRd, LdValid=1 in the same cycle. Stall=0. Zero-latency.
- IDLE, misaligned load:
  - Issue word read at A0={Addr[31:2],00}, capture Dcache_DataRd into lo_reg.
  - Stall=1, LdValid=0, go to LD_HI.
- LD_HI:
  - Issue word read at A1=A0+4 (modulo 2^ADDR_WIDTH; 0xFFFFFFFC wraps to 0x00000000).
  - Merge: concatenate {Dcache_DataRd, lo_reg}, shift right by 8*Addr[1:0], take 16 or 32 LSBs, sign/zero-extend per EXMem_Sign.
  - LdValid=1, Stall=0, return to IDLE. Total 1 stall cycle.
- IDLE, misaligned store:
  - N = 2 (halfword) or 4 (word) bytes; counter k=0.
  - Issue byte write (Width=00) at Addr+k, data Rs2Data[8k+:8] in bits [7:0].
  - Stall=1, go to ST_BYTE with k=1.
- ST_BYTE:
  - Issue byte write for k at Addr+k (wraps modulo 2^ADDR_WIDTH).
  - If k=N-1: Stall=0, go to IDLE. Else k++, Stall=1.
  - Total stall N-1 cycles; exactly N cache writes, each one cycle.
- Stall timing: Lsu_Stall is combinational from state and request, asserted in the first cycle of a split.
- Cache signals when idle with no request: EN=0, other cache outputs 0.
- Lsu_LdData is 0 whenever LdValid=0.
- No new request is accepted until the state machine returns to IDLE; inputs must stay stable while stalled.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - No splitting; LD_HI and ST_BYTE are unused.
  - A misaligned request drives EN=0 and pulses Lsu_MisalignErr=1 for one cycle, with Stall=0 and LdValid=0.
  - Aligned behaviour is unchanged.
- Undefined:
  - Split behaviour as above.
  - Lsu_MisalignErr tied 0.

Test Plan:
- Aligned word load, Addr=0x100, memory 0x100=0xDEADBEEF:
  - same cycle LdData=0xDEADBEEF, LdValid=1, Stall=0.
- Misaligned word load, Addr=0x102, words 0x100=0x33221100, 0x104=0x77665544:
  - reads at 0x100 then 0x104; Stall=1 for 1 cycle; LdData=0x55443322.
- Misaligned signed halfword load, Addr=0x103, byte 0x103=0xF0, byte 0x104=0x8A:
  - LdData=0xFFFF8AF0 after 1 stall cycle.
- Misaligned word store, Addr=0x201, Rs2Data=0xAABBCCDD:
  - 4 byte writes DD, CC, BB, AA at 0x201..0x204; Stall=1 for 3 cycles.
  - Readback: word 0x200=0xBBCCDDxx, 0x204 byte0=0xAA.
- Reset asserted in 2nd ST_BYTE cycle:
  - outputs 0 immediately; bytes 0x201, 0x202 written, 0x203 untouched; next request handled from IDLE.
- MISALIGN_TRAP_EN defined, word load Addr=0x102:
  - Lsu_MisalignErr=1 one cycle, Mem_DcacheEN=0, Stall=0, LdValid=0.
